// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move interface.
package ttt_pkg;

    typedef logic [3:0] move_t;

    localparam move_t IDLE_MOVE = 4'hF;
    localparam int    NUM_SQ    = 9;

    typedef enum logic [1:0] {
        W_NONE  = 2'b00,
        W_HUMAN = 2'b01,
        W_COMP  = 2'b10,
        W_DRAW  = 2'b11
    } winner_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT_H,
        S_DRIVE,
        S_CAPT,
        S_DONE
    } state_t;

    // Three rows, three columns, two diagonals; bit i = square i.
    localparam logic [7:0][NUM_SQ-1:0] WIN_LINES = {
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    // One-hot square mask; out-of-range moves map to an empty mask.
    function automatic logic [NUM_SQ-1:0] sq_mask(input move_t m);
        for (int i = 0; i < NUM_SQ; i++) begin
            sq_mask[i] = (m == move_t'(i));
        end
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags a board mask that covers any win line.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [NUM_SQ-1:0] mask_i,
    output logic              win_o
);

    always_comb begin
        win_o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((mask_i & WIN_LINES[i]) == WIN_LINES[i]) begin
                win_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_player_ctrl.sv
// Human-side tic-tac-toe controller: validates switch moves, hands them to the
// computer FSM for one cycle, captures the reply and tracks the game result.
module ttt_player_ctrl
    import ttt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        sw_move,
    input  logic              enter,
    input  logic [3:0]        c_move,
    output logic [3:0]        h_move,
    output logic [NUM_SQ-1:0] human_board,
    output logic [NUM_SQ-1:0] comp_board,
    output logic              turn_ready,
    output logic              illegal,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              proto_err
);

    state_t            state_q;
    move_t             h_move_q;
    move_t             last_q;
    logic [NUM_SQ-1:0] hb_q, cb_q;
    logic              turn_q, ill_q, over_q, perr_q;
    winner_t           win_q;

    logic [NUM_SQ-1:0] hb_d, cb_d, c_mask, occ;
    logic              req_bad, c_pass, c_bad, h_win, c_win, full;

    assign occ     = hb_q | cb_q;
    assign req_bad = (sw_move > 4'd8) || |(sq_mask(sw_move) & occ);

    // h_move_q holds the latched request while in S_DRIVE.
    assign hb_d    = hb_q | sq_mask(h_move_q);

    // An unchanged c_move means the computer passed this turn.
    assign c_mask  = sq_mask(c_move);
    assign c_pass  = (c_move == last_q);
    assign c_bad   = !c_pass && ((c_move > 4'd8) || |(c_mask & occ));
    assign cb_d    = c_pass ? cb_q : (cb_q | c_mask);
    assign full    = &(hb_q | cb_d);

    ttt_win_check u_human_win (.mask_i(hb_d), .win_o(h_win));
    ttt_win_check u_comp_win  (.mask_i(cb_d), .win_o(c_win));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            h_move_q <= IDLE_MOVE;
            last_q   <= IDLE_MOVE;
            hb_q     <= '0;
            cb_q     <= '0;
            turn_q   <= 1'b0;
            ill_q    <= 1'b0;
            over_q   <= 1'b0;
            perr_q   <= 1'b0;
            win_q    <= W_NONE;
        end else begin
            ill_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    cb_q    <= c_mask;
                    last_q  <= c_move;
                    turn_q  <= 1'b1;
                    state_q <= S_WAIT_H;
                end
                S_WAIT_H: begin
                    if (enter) begin
                        if (req_bad) begin
                            ill_q <= 1'b1;
                        end else begin
                            h_move_q <= sw_move;
                            turn_q   <= 1'b0;
                            state_q  <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    h_move_q <= IDLE_MOVE;
                    hb_q     <= hb_d;
                    if (h_win) begin
                        win_q   <= W_HUMAN;
                        over_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (c_bad) begin
                        perr_q  <= 1'b1;
                        over_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cb_q   <= cb_d;
                        last_q <= c_move;
                        if (c_win) begin
                            win_q   <= W_COMP;
                            over_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (full) begin
                            win_q   <= W_DRAW;
                            over_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            turn_q  <= 1'b1;
                            state_q <= S_WAIT_H;
                        end
                    end
                end
                S_DONE: begin
                    h_move_q <= IDLE_MOVE;
                    turn_q   <= 1'b0;
                end
                default: state_q <= S_DONE;
            endcase
        end
    end

    assign h_move      = h_move_q;
    assign human_board = hb_q;
    assign comp_board  = cb_q;
    assign turn_ready  = turn_q;
    assign illegal     = ill_q;
    assign game_over   = over_q;
    assign winner      = win_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_ttt_player_ctrl.sv
// Bench for ttt_player_ctrl: scripted computer stub plus a game-level model.
module tb_ttt_player_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_move = 4'd0;
    logic       enter = 1'b0;
    logic [3:0] c_move;
    logic [3:0] h_move;
    logic [8:0] human_board, comp_board;
    logic       turn_ready, illegal, game_over, proto_err;
    logic [1:0] winner;

    always #5 clk = ~clk;

    ttt_player_ctrl dut (
        .clk(clk), .rst(rst), .sw_move(sw_move), .enter(enter), .c_move(c_move),
        .h_move(h_move), .human_board(human_board), .comp_board(comp_board),
        .turn_ready(turn_ready), .illegal(illegal), .game_over(game_over),
        .winner(winner), .proto_err(proto_err)
    );

    // Computer stub: state jumps to the scripted reply on any edge that sees a move.
    logic [3:0] comp_q;
    logic [3:0] opening_v = 4'd4;
    logic [3:0] reply_v   = 4'd4;
    always @(posedge clk) begin
        if (rst)                comp_q <= opening_v;
        else if (h_move != 4'hF) comp_q <= reply_v;
    end
    assign c_move = comp_q;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic prev_act = 1'b0;
    always @(negedge clk) begin
        if (!rst && h_move !== 4'hF) chk("h_move_one_cycle", prev_act, 0);
        prev_act <= !rst && (h_move !== 4'hF);
    end

    // Game model
    int LINES[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [8:0] m_hb, m_cb;
    int m_last, m_win;
    bit m_over, m_perr;

    function automatic bit has_line(input logic [8:0] b);
        for (int i = 0; i < 8; i++)
            if (b[LINES[i][0]] && b[LINES[i][1]] && b[LINES[i][2]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit occ(input int s);
        return (s <= 8) && (m_hb[s] || m_cb[s]);
    endfunction

    function automatic int pick_free(input int excl);
        int q[$];
        for (int s = 0; s < 9; s++) if (!occ(s) && s != excl) q.push_back(s);
        if (q.size() == 0) return -1;
        return q[$urandom % q.size()];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_human_board"}, human_board, m_hb);
        chk({tag, "_comp_board"}, comp_board, m_cb);
        chk({tag, "_winner"}, winner, m_win);
        chk({tag, "_game_over"}, game_over, m_over);
        chk({tag, "_proto_err"}, proto_err, m_perr);
        chk({tag, "_turn_ready"}, turn_ready, !m_over);
        chk({tag, "_h_move"}, h_move, 4'hF);
    endtask

    // Asserts rst immediately; returns at the negedge of the first playable cycle.
    task automatic do_reset(input int opening);
        rst = 1'b1; enter = 1'b0; opening_v = opening[3:0];
        @(negedge clk);
        chk("rst_h_move", h_move, 4'hF);
        chk("rst_human_board", human_board, 0);
        chk("rst_comp_board", comp_board, 0);
        chk("rst_turn_ready", turn_ready, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_proto_err", proto_err, 0);
        rst = 1'b0;
        m_hb = '0; m_cb = '0; m_cb[opening] = 1'b1; m_last = opening;
        m_over = 0; m_win = 0; m_perr = 0;
        @(negedge clk);
        check_state("open");
    endtask

    task automatic play(input int sq, input int reply);
        logic [3:0] exp_h;
        bit exp_ill, exp_tr;
        exp_h = 4'hF; exp_ill = 0; exp_tr = 0;
        if (!m_over) begin
            if (sq > 8 || occ(sq)) begin
                exp_ill = 1; exp_tr = 1;
            end else begin
                exp_h = sq[3:0];
                m_hb[sq] = 1'b1;
                if (has_line(m_hb)) begin
                    m_win = 1; m_over = 1;
                end else begin
                    if (reply != m_last) begin
                        if (reply > 8 || occ(reply)) begin
                            m_perr = 1; m_over = 1;
                        end else begin
                            m_cb[reply] = 1'b1; m_last = reply;
                        end
                    end
                    if (!m_over) begin
                        if (has_line(m_cb)) begin m_win = 2; m_over = 1; end
                        else if ((m_hb | m_cb) == 9'h1FF) begin m_win = 3; m_over = 1; end
                    end
                end
            end
        end
        sw_move = sq[3:0]; reply_v = reply[3:0]; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        chk("k1_h_move", h_move, exp_h);
        chk("k1_illegal", illegal, exp_ill);
        chk("k1_turn_ready", turn_ready, exp_tr);
        @(negedge clk);
        chk("k2_h_move", h_move, 4'hF);
        chk("k2_illegal", illegal, 0);
        @(negedge clk);
        check_state("k3");
    endtask

    initial begin
        int sq, reply, r;

        // Diagonal {2,4,6} computer win
        do_reset(4);
        play(7, 2);
        play(0, 6);
        chk("diag_comp_board", comp_board, 9'b001010100);
        chk("diag_winner", winner, 2'b10);

        // Column {2,5,8} win, then ignored enter
        do_reset(4);
        play(7, 2);
        play(6, 8);
        play(0, 5);
        chk("col_comp_board", comp_board, 9'b100110100);
        play(1, 3);

        // Occupied and out-of-range requests
        do_reset(4);
        play(4, 0);
        play(9, 0);
        play(15, 0);

        // Computer replies with a human-owned square
        do_reset(4);
        play(7, 7);
        chk("perr_flag", proto_err, 1);
        chk("perr_winner", winner, 0);

        // Human column {0,3,6}; reply not recorded
        do_reset(4);
        play(0, 1);
        play(3, 2);
        play(6, 8);
        chk("hwin_winner", winner, 2'b01);

        // Draw
        do_reset(4);
        play(0, 2);
        play(6, 3);
        play(5, 1);
        play(7, 8);
        chk("draw_winner", winner, 2'b11);

        // Pass: computer repeats its last square
        do_reset(4);
        play(0, 4);
        play(1, 8);

        // Reset during S_CAPT
        do_reset(4);
        play(0, 1);
        sw_move = 4'd3; reply_v = 4'd5; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        chk("mid_h_move", h_move, 4'd3);
        @(negedge clk);
        do_reset(4);
        play(8, 0);

        // Randomized games
        for (int g = 0; g < 40; g++) begin
            do_reset($urandom % 9);
            for (int m = 0; m < 12 && !m_over; m++) begin
                if ($urandom % 5 == 0) sq = $urandom % 16;
                else sq = pick_free(-1);
                if (sq < 0) sq = 9;
                r = $urandom % 10;
                if (r == 0) reply = m_last;
                else if (r == 1) reply = $urandom % 16;
                else begin
                    reply = pick_free(sq);
                    if (reply < 0) reply = m_last;
                end
                play(sq, reply);
            end
            if (m_over) play($urandom % 9, $urandom % 9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
